user_io_event_gen: RTL
======================

// Module: user_io_event_gen
// PURPOSE
//  Consumes the polled TCA9555 status (o_button[5:0], o_link_pow[3:0]) from user_io.
//  Debounces each bit, detects committed level changes, and timestamps each change.
//  Queues change events in a small FWFT FIFO and presents them on a valid/ready stream for the host register path.
//  Also exports the debounced status vector and a sticky overflow flag.
// PARAMETERS
//  DEBOUNCE_CYCLES  160_000  consecutive mismatch cycles before a bit commits (10 ms @16 MHz); must be >= 1
//  TICK_DIV         16_000   i_clk cycles per timestamp tick (1 ms @16 MHz); must be >= 1
//  FIFO_DEPTH       8        event FIFO entries; power of 2, >= 2
// PORTS
//  i_clk            in   1   system clock (same domain as user_io; no synchronisers needed)
//  i_reset_n        in   1   asynchronous active-low reset
//  i_button         in   6   raw button levels from user_io o_button
//  i_link_pow       in   4   raw link-power levels from user_io o_link_pow
//  o_state          out  10  debounced status {link_pow[3:0], button[5:0]}
//  o_evt_valid      out  1   event word available at FIFO head
//  i_evt_ready      in   1   consumer accepts head when o_evt_valid & i_evt_ready
//  o_evt_data       out  24  [23:8] timestamp, [7:5] 3'b000, [4] new level, [3:0] bit index 0..9
//  o_fill           out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  o_overflow       out  1   sticky: an event was dropped
//  i_clr_overflow   in   1   synchronous clear of o_overflow
// BEHAVIOUR
//  Reset (async assert, sync to i_clk on release): o_state=0, debounce counters=0, pending=0.
//  Also on reset: timestamp=0, tick prescaler=0, FIFO empty, o_evt_valid=0, o_fill=0, o_overflow=0, o_evt_data=0.
//  Reset asserted mid-operation discards queued and pending events; no event is generated for reset itself.
//  raw[9:0] = {i_link_pow, i_button}.
//  Debounce, per bit k:
//   - If raw[k]==o_state[k], cnt[k]<=0.
//   - Otherwise cnt[k] increments. On the DEBOUNCE_CYCLES-th consecutive mismatch cycle: o_state[k]<=raw[k], cnt[k]<=0, pending[k]<=1.
//   - A single-cycle match restarts the count.
//  Timestamp:
//   - Prescaler counts 0..TICK_DIV-1. On the wrap cycle, the 16-bit timestamp increments.
//   - Timestamp wraps 0xFFFF->0x0000 silently.
//  Emit:
//   - Each cycle, if pending!=0, pick the lowest set index j and form {timestamp, 3'b0, o_state[j], j}.
//   - Clear pending[j] and attempt a push, so one event per cycle.
//   - A bit that commits on the same cycle as its emit remains pending.
//  Push/pop:
//   - pop = o_evt_valid & i_evt_ready. A push is accepted if FIFO not full, or if full and pop in the same cycle.
//   - A simultaneous push and pop leaves o_fill unchanged.
//   - A rejected push drops the event and sets o_overflow. Pending is still cleared.
//  Overflow flag:
//   - i_clr_overflow clears o_overflow. If a drop occurs in the same cycle, set wins.
//  FIFO is first-word-fall-through:
//   - o_evt_valid rises the cycle after the first push into an empty FIFO.
//   - o_evt_data is stable while o_evt_valid & !i_evt_ready.
//  Latency: raw change held stable from cycle 0 -> o_state at edge DEBOUNCE_CYCLES -> push on the next edge (if lowest pending) -> o_evt_valid one cycle later.
//  Ordering: FIFO order = emit order. Simultaneous commits are emitted ascending by index; all carry their own emit-cycle timestamp.
// TESTING (bench params: DEBOUNCE_CYCLES=4, TICK_DIV=2, FIFO_DEPTH=4)
//  1. i_button[0]=1 for 3 cycles, then 0 -> o_state stays 0; no event; o_fill=0.
//  2. i_button[2]=1 held -> o_state[2]=1 after 4 cycles; one event with [4]=1, [3:0]=2; timestamp equals the tick count at the emit cycle.
//  3. i_link_pow=4'hF and i_button=6'h3F change together, i_evt_ready=0 -> 10 commits in one cycle; first 4 events (idx 0..3) queued, o_fill=4; remaining 6 dropped; o_overflow=1.
//  4. FIFO full, i_evt_ready=1 on the same cycle a new event is emitted -> event accepted, o_fill stays 4, o_overflow unchanged; then i_clr_overflow=1 -> o_overflow=0.
//  5. Timestamp preset near 0xFFFF by running 131070 cycles, then trigger change -> event timestamps 0xFFFF then 0x0000 in order, no glitch.
//  6. Assert i_reset_n=0 asynchronously with 3 events queued and 2 pending -> outputs 0 immediately; after release no events appear until new debounced changes occur.

Source files
------------

// File: rtl/user_io_event_gen.sv
// user_io_event_gen: debounces the polled button/link-power status bits.
// Each committed level change becomes a timestamped event word.
// Events are queued in a small first-word-fall-through FIFO and
// presented to the host on a valid/ready stream.
module user_io_event_gen #(
    parameter int DEBOUNCE_CYCLES = 160_000,
    parameter int TICK_DIV        = 16_000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [5:0]                    i_button,
    input  logic [3:0]                    i_link_pow,
    output logic [9:0]                    o_state,
    output logic                          o_evt_valid,
    input  logic                          i_evt_ready,
    output logic [23:0]                   o_evt_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill,
    output logic                          o_overflow,
    input  logic                          i_clr_overflow
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FILL_FULL  = FW'(FIFO_DEPTH);

    logic [9:0]    raw;
    logic [CW-1:0] cnt [10];
    logic [9:0]    commit;
    logic [9:0]    pending;
    logic [9:0]    emit_mask;
    logic [3:0]    emit_idx;
    logic          emit_any;
    logic [23:0]   emit_word;
    logic [PW-1:0] presc;
    logic [15:0]   timestamp;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] count;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign raw = {i_link_pow, i_button};

    // A bit commits on its last consecutive mismatch cycle
    always_comb begin
        commit = '0;
        for (int k = 0; k < 10; k++) begin
            commit[k] = (raw[k] != o_state[k]) && (cnt[k] == CNT_LAST);
        end
    end

    // Per-bit debounce counters and the committed status vector
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_state <= '0;
            for (int k = 0; k < 10; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 10; k++) begin
                if (raw[k] == o_state[k]) begin
                    cnt[k] <= '0;
                end else if (commit[k]) begin
                    cnt[k]     <= '0;
                    o_state[k] <= raw[k];
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // Pick the lowest pending bit and build its event word
    always_comb begin
        emit_idx = '0;
        emit_any = |pending;
        for (int k = 9; k >= 0; k--) begin
            if (pending[k]) begin
                emit_idx = 4'(k);
            end
        end
        emit_mask = emit_any ? (10'b1 << emit_idx) : '0;
        emit_word = {timestamp, 3'b000, o_state[emit_idx], emit_idx};
    end

    // Pending set: the emitted bit is cleared unless it commits again this cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~emit_mask) | commit;
        end
    end

    // Tick prescaler and free-running 16-bit timestamp
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc     <= '0;
            timestamp <= '0;
        end else if (presc == PRESC_LAST) begin
            presc     <= '0;
            timestamp <= timestamp + 16'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign full    = (count == FILL_FULL);
    assign pop     = o_evt_valid & i_evt_ready;
    assign push_ok = emit_any & (!full | pop);
    assign drop    = emit_any & !push_ok;

    // Event storage; contents need no reset because count gates visibility
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= emit_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a drop wins over a clear in the same cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
        end
    end

    assign o_evt_valid = (count != '0);
    assign o_evt_data  = o_evt_valid ? mem[rd_ptr] : '0;
    assign o_fill      = count;

endmodule
